call_panel: RTL and testbench
=============================

Name: call_panel

Overview:
- Producer side of the elevator request interface: turns raw floor call buttons into the `req` bus consumed by the elevator controller, and lights per-floor call lamps.
- Each floor channel runs three stages: synchronise, debounce, then latch the call as pending. The `req` pulse is (re)issued while pending.
- A call clears when the car reports door open at that floor. The next call is suppressed until the button is released.
- Sits between the panel I/O pads and the controller; it reads the controller's `floor`/`door`/`moving` outputs back.

Parameters:
- NUM_FLOORS, 4, number of floors/buttons.
- FLOOR_W, 2, width of the floor index (must be >= clog2(NUM_FLOORS)).
- DEBOUNCE_CYCLES, 8, consecutive synchronised-high cycles needed to accept a press (min 1).
- CNT_W, 4, width of the debounce and repost counters (must hold max(DEBOUNCE_CYCLES, REPOST_INTERVAL)-1).
- REPOST_INTERVAL, 16, cycles between repeated req pulses while pending; 0 disables repost.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn  in  NUM_FLOORS  raw asynchronous call buttons, 1 = pressed.
- floor  in  FLOOR_W  current car floor from the controller.
- door  in  1  car door open (1 = open).
- moving  in  1  car moving (1 = yes).
- req  out  NUM_FLOORS  registered; one-cycle request pulse per floor.
- lamp  out  NUM_FLOORS  registered; call acknowledged/pending indicator.
- any_pending  out  1  registered; OR of all lamps.

Behaviour:
- Reset is asynchronous, active-high, clock is clk. On reset:
  - req, lamp and any_pending are 0.
  - Synchroniser flops are 0, all channels go to C_IDLE, and all counters are 0.
  - Pending calls are discarded; reset mid-operation behaves identically.
- Synchroniser: btn[i] passes through 2 flops to give btn_s[i]. No combinational path from btn to any output.
- service[i] = door && !moving && (floor == i), evaluated each cycle.
- Channel FSM (independent per floor, states C_IDLE, C_DEBOUNCE, C_PENDING, C_HOLD):
  - C_IDLE: if btn_s → C_DEBOUNCE, cnt = 0. Else stay.
  - C_DEBOUNCE: if !btn_s → C_IDLE (glitch rejected, no output).
  - C_DEBOUNCE, btn_s and cnt == DEBOUNCE_CYCLES-1:
    - if service[i] → C_HOLD (car already here, no req, no lamp);
    - else → C_PENDING with req[i] = 1 for one cycle, lamp[i] = 1, repost timer = 0.
  - C_DEBOUNCE, btn_s and cnt below terminal value: cnt++.
  - C_PENDING: lamp[i] held at 1.
    - If service[i] → lamp[i] = 0 next cycle, no req that cycle; next state is C_HOLD if btn_s, else C_IDLE.
    - Else, with REPOST_INTERVAL != 0: timer++. When timer == REPOST_INTERVAL-1, req[i] = 1 for one cycle and timer = 0.
  - C_HOLD: wait for !btn_s → C_IDLE. A held button never re-issues a call.
- Latency: with btn held stable, req[i] and lamp[i] rise at the DEBOUNCE_CYCLES+3rd rising edge after btn[i] is first sampled high.
  - 2 edges for the synchroniser, 1 edge for C_IDLE → C_DEBOUNCE, DEBOUNCE_CYCLES edges of counting.
- Clear latency: lamp[i] falls at the edge after the first cycle in which service[i] is seen in C_PENDING.
- Simultaneous events:
  - Service and repost terminal in the same cycle: service wins, req stays 0.
  - Multiple floors may pulse req in the same cycle; channels never interact.
  - A press on a floor already pending is ignored.
- Out-of-range floor values (>= NUM_FLOORS) match no channel.
- any_pending is registered from next-state lamp values, so it is coincident with lamp.
- req is a pulse by contract. The controller ORs it into its request register, so repeated pulses are idempotent.

Decomposition:
- Package call_panel_pkg:
  - channel state typedef (C_IDLE, C_DEBOUNCE, C_PENDING, C_HOLD, 2-bit encoding);
  - default parameter constants.
- One sub-module, call_channel: synchroniser, FSM and counters for a single floor. It takes parameter FLOOR_ID and produces req/lamp bits.
- call_panel instantiates NUM_FLOORS call_channel instances in a generate loop and ORs lamps into any_pending.

Test Plan (DEBOUNCE_CYCLES = 4, REPOST_INTERVAL = 8 unless stated):
1. Reset asserted mid-C_PENDING on floor 2 → req = 0000, lamp = 0000, any_pending = 0 immediately. After release, btn held 0 → outputs stay 0.
2. btn = 0100, held, floor = 0, door = 0 → req = 0100 for exactly one cycle at edge 7, lamp = 0100 from edge 7, any_pending = 1. Repeat req pulses every 8 cycles thereafter.
3. btn[1] high for 3 cycles then low → no req, no lamp. A 5-cycle press → accepted.
4. Floor 3 pending; drive floor = 3, door = 1, moving = 0 with btn[3] still held → lamp[3] falls next edge, no req[3] pulse that cycle or later. btn[3] released then re-pressed → new call accepted.
5. Press btn[0] while floor = 0, door = 1, moving = 0 throughout the debounce → no req, no lamp, channel goes to C_HOLD. Same press with moving = 1 → call accepted.
6. btn = 1011 pressed on the same edge → req = 1011 on one cycle. Service floor 1 only → lamp = 1001. Set REPOST_INTERVAL = 0 → no further req pulses.

Source files
------------

// File: rtl/call_panel_pkg.sv
// Shared types and default parameters for the floor call panel.
// Every file that needs the channel state encoding imports this package.
package call_panel_pkg;

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_DEBOUNCE = 2'd1,
        C_PENDING  = 2'd2,
        C_HOLD     = 2'd3
    } chan_state_t;

    localparam int DEF_NUM_FLOORS      = 4;
    localparam int DEF_FLOOR_W         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_CNT_W           = 4;
    localparam int DEF_REPOST_INTERVAL = 16;

endpackage

// File: rtl/call_channel.sv
// One floor's call path: 2-flop synchroniser, debounce, pending latch with
// periodic repost of the one-cycle req pulse, and hold-until-release.
module call_channel
    import call_panel_pkg::*;
#(
    parameter int FLOOR_ID        = 0,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPOST_INTERVAL = DEF_REPOST_INTERVAL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               door,
    input  logic               moving,
    output logic               req,
    output logic               lamp,
    output logic               lamp_next,
    output chan_state_t        state
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST =
        (REPOST_INTERVAL == 0) ? '0 : CNT_W'(REPOST_INTERVAL - 1);

    logic [1:0]       sync;
    logic             btn_s;
    logic             service;
    chan_state_t      state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] tmr, tmr_n;
    logic             req_n;

    assign btn_s   = sync[1];
    assign service = door && !moving && (floor == FLOOR_W'(FLOOR_ID));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            state <= C_IDLE;
            cnt   <= '0;
            tmr   <= '0;
            req   <= 1'b0;
            lamp  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_n;
            cnt   <= cnt_n;
            tmr   <= tmr_n;
            req   <= req_n;
            lamp  <= lamp_next;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmr_n   = tmr;
        req_n   = 1'b0;
        case (state)
            C_IDLE: begin
                if (btn_s) begin
                    state_n = C_DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            C_DEBOUNCE: begin
                if (!btn_s) begin
                    state_n = C_IDLE;
                end else if (cnt == DEB_LAST) begin
                    // Car already standing open at this floor: swallow the press.
                    if (service) begin
                        state_n = C_HOLD;
                    end else begin
                        state_n = C_PENDING;
                        req_n   = 1'b1;
                        tmr_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            C_PENDING: begin
                // Service beats a coincident repost terminal count.
                if (service) begin
                    state_n = btn_s ? C_HOLD : C_IDLE;
                end else if (REPOST_INTERVAL != 0) begin
                    if (tmr == REP_LAST) begin
                        req_n = 1'b1;
                        tmr_n = '0;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
            end
            C_HOLD: begin
                if (!btn_s) state_n = C_IDLE;
            end
            default: state_n = C_IDLE;
        endcase
    end

    assign lamp_next = (state_n == C_PENDING);

endmodule

// File: rtl/call_panel.sv
// Floor call panel: one independent call_channel per floor; req is a one-cycle
// pulse the controller ORs into its request register, so reposts are harmless.
module call_panel
    import call_panel_pkg::*;
#(
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPOST_INTERVAL = DEF_REPOST_INTERVAL
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_FLOORS-1:0]            btn,
    input  logic [FLOOR_W-1:0]               floor,
    input  logic                             door,
    input  logic                             moving,
    output logic [NUM_FLOORS-1:0]            req,
    output logic [NUM_FLOORS-1:0]            lamp,
    output logic                             any_pending,
    output chan_state_t [NUM_FLOORS-1:0]     chan_state
);

    logic [NUM_FLOORS-1:0] lamp_next;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_chan
        call_channel #(
            .FLOOR_ID        (i),
            .FLOOR_W         (FLOOR_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPOST_INTERVAL (REPOST_INTERVAL)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[i]),
            .floor     (floor),
            .door      (door),
            .moving    (moving),
            .req       (req[i]),
            .lamp      (lamp[i]),
            .lamp_next (lamp_next[i]),
            .state     (chan_state[i])
        );
    end

    // Built from next-state lamps so it changes on the same edge as lamp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_pending <= 1'b0;
        else       any_pending <= |lamp_next;
    end

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: two instances (repost 8 and repost 0) share stimulus
// and are compared every cycle against a behavioural call model.
module tb_call_panel;
    import call_panel_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] btn;
    logic [1:0] floor;
    logic door, moving;

    logic [3:0] req_a, lamp_a, req_b, lamp_b;
    logic any_a, any_b;
    chan_state_t [3:0] st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state, index 0 = repost 8, index 1 = repost off
    logic [3:0] q1, q2;
    int run [2][4];
    bit pend [2][4];
    bit blk [2][4];
    int age [2][4];
    logic [3:0] exp_req [2];
    logic [3:0] exp_lamp [2];

    always #5 clk = ~clk;

    call_panel #(.NUM_FLOORS(4), .FLOOR_W(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(4),
                 .REPOST_INTERVAL(8)) dut_a (
        .clk(clk), .reset(reset), .btn(btn), .floor(floor), .door(door),
        .moving(moving), .req(req_a), .lamp(lamp_a), .any_pending(any_a),
        .chan_state(st_a));

    call_panel #(.NUM_FLOORS(4), .FLOOR_W(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(4),
                 .REPOST_INTERVAL(0)) dut_b (
        .clk(clk), .reset(reset), .btn(btn), .floor(floor), .door(door),
        .moving(moving), .req(req_b), .lamp(lamp_b), .any_pending(any_b),
        .chan_state(st_b));

    function automatic int rep_of(int m);
        return (m == 0) ? 8 : 0;
    endfunction

    task automatic model_reset();
        q1 = '0;
        q2 = '0;
        for (int m = 0; m < 2; m++) begin
            exp_req[m]  = '0;
            exp_lamp[m] = '0;
            for (int i = 0; i < 4; i++) begin
                run[m][i] = 0; pend[m][i] = 0; blk[m][i] = 0; age[m][i] = 0;
            end
        end
    endtask

    // A call is accepted after DEB+1 consecutive edges of a high synchronised
    // button while the floor is neither pending nor waiting for a release.
    task automatic model_step();
        logic [3:0] b;
        bit svc;
        if (reset) begin
            model_reset();
            return;
        end
        b  = q2;
        q2 = q1;
        q1 = btn;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                svc = door && !moving && (int'(floor) == i);
                exp_req[m][i] = 1'b0;
                if (pend[m][i]) begin
                    if (svc) begin
                        pend[m][i] = 0;
                        blk[m][i]  = b[i];
                    end else if (rep_of(m) != 0) begin
                        age[m][i]++;
                        if (age[m][i] == rep_of(m)) begin
                            exp_req[m][i] = 1'b1;
                            age[m][i] = 0;
                        end
                    end
                end else if (blk[m][i]) begin
                    if (!b[i]) blk[m][i] = 0;
                end else begin
                    run[m][i] = b[i] ? run[m][i] + 1 : 0;
                    if (run[m][i] == DEB + 1) begin
                        run[m][i] = 0;
                        if (svc) begin
                            blk[m][i] = 1;
                        end else begin
                            pend[m][i] = 1;
                            exp_req[m][i] = 1'b1;
                            age[m][i] = 0;
                        end
                    end
                end
                exp_lamp[m][i] = pend[m][i];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; btn = '0; floor = '0; door = 1'b0; moving = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn = '0; floor = '0; door = 1'b0; moving = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got a=%b/%b/%b b=%b/%b/%b exp all zero",
                     req_a, lamp_a, any_a, req_b, lamp_b, any_b);
        end
        n_tests++;
        if (st_a !== {4{C_IDLE}}) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", st_a, {4{C_IDLE}});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        btn = 4'b0100;
        floor = 2'(($urandom_range(0, 2) + 3) % 4);
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL mid_reset_run c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async got a=%b/%b/%b b=%b/%b/%b exp all zero",
                     req_a, lamp_a, any_a, req_b, lamp_b, any_b);
        end
        @(negedge clk);
        reset = 1'b0;
        btn = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !== 10'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet c=%0d got a=%b/%b/%b b=%b/%b/%b exp all zero",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b);
            end
        end
    endtask

    task automatic test_latency();
        int first_req;
        int n_req;
        do_reset();
        first_req = -1;
        n_req = 0;
        btn = 4'b0100;
        floor = 2'($urandom_range(0, 1));
        for (int c = 1; c <= 40; c++) begin
            moving = 1'($urandom_range(0, 1));
            tick();
            if (req_a[2]) begin
                if (first_req < 0) first_req = c;
                n_req++;
            end
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL latency_cycle c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
        end
        n_tests++;
        if (first_req != DEB + 3) begin
            n_fail++;
            $display("FAIL latency_first_req got edge %0d exp edge %0d", first_req, DEB + 3);
        end
        n_tests++;
        if (n_req != 1 + (40 - (DEB + 3)) / 8) begin
            n_fail++;
            $display("FAIL latency_repost_count got %0d exp %0d", n_req, 1 + (40 - (DEB + 3)) / 8);
        end
    endtask

    task automatic test_glitch();
        int len;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            len = (pass == 0) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB + 1, DEB + 3);
            for (int c = 0; c < len + 10; c++) begin
                btn[1] = (c < len);
                tick();
                n_tests++;
                if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                    {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                    n_fail++;
                    $display("FAIL glitch_cycle len=%0d c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                             len, c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                             exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
                end
            end
            n_tests++;
            if (lamp_a[1] !== (pass == 1)) begin
                n_fail++;
                $display("FAIL glitch_lamp len=%0d got %b exp %b", len, lamp_a[1], pass == 1);
            end
        end
    endtask

    task automatic test_service();
        bit saw_req;
        do_reset();
        saw_req = 0;
        btn[3] = 1'b1;
        for (int c = 0; c < 8 + 14 + 14; c++) begin
            if (c == 8)  begin floor = 2'd3; door = 1'b1; moving = 1'b0; end
            if (c == 22) begin btn[3] = 1'b0; door = 1'b0; end
            if (c == 26) btn[3] = 1'b1;
            tick();
            if (c >= 8 && c < 22 && req_a[3]) saw_req = 1;
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL service_cycle c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
            if (c == 8) begin
                n_tests++;
                if (lamp_a[3] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL service_clear got lamp3=%b exp 0", lamp_a[3]);
                end
            end
            if (c == 21) begin
                n_tests++;
                if (st_a[3] !== C_HOLD) begin
                    n_fail++;
                    $display("FAIL service_hold got state %0d exp %0d", st_a[3], C_HOLD);
                end
            end
        end
        n_tests++;
        if (saw_req) begin
            n_fail++;
            $display("FAIL service_no_req got req3 pulse while held exp none");
        end
        n_tests++;
        if (lamp_a[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL service_repress got lamp3=%b exp 1", lamp_a[3]);
        end
    endtask

    task automatic test_hold();
        do_reset();
        floor = 2'd0; door = 1'b1; moving = 1'b0;
        for (int c = 0; c < 26; c++) begin
            btn[0] = !(c >= 12 && c < 16);
            moving = (c >= 16);
            tick();
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL hold_cycle c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
            if (c == 11) begin
                n_tests++;
                if (st_a[0] !== C_HOLD || lamp_a[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_at_floor got state %0d lamp0=%b exp state %0d lamp0=0",
                             st_a[0], lamp_a[0], C_HOLD);
                end
            end
        end
        n_tests++;
        if (lamp_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_moving_accept got lamp0=%b exp 1", lamp_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n_full;
        int n_req_b;
        do_reset();
        n_full = 0;
        n_req_b = 0;
        btn = 4'b1011;
        for (int c = 0; c < 44; c++) begin
            if (c == 10) begin btn = '0; floor = 2'd1; door = 1'b1; moving = 1'b0; end
            if (c == 12) door = 1'b0;
            tick();
            if (req_a === 4'b1011) n_full++;
            if (c >= 12 && req_b !== 4'b0000) n_req_b++;
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL b2b_cycle c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
            if (c == 11) begin
                n_tests++;
                if (lamp_a !== 4'b1001 || lamp_b !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL b2b_service1 got lamp_a=%b lamp_b=%b exp 1001", lamp_a, lamp_b);
                end
            end
        end
        n_tests++;
        if (n_full != 1) begin
            n_fail++;
            $display("FAIL b2b_joint_req got %0d cycles of 1011 exp 1", n_full);
        end
        n_tests++;
        if (n_req_b != 0) begin
            n_fail++;
            $display("FAIL b2b_no_repost got %0d req cycles exp 0", n_req_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
            floor  = 2'($urandom_range(0, 3));
            door   = ($urandom_range(0, 3) == 0);
            moving = 1'($urandom_range(0, 1));
            tick();
            n_tests++;
            if ({req_a, lamp_a, any_a, req_b, lamp_b, any_b} !==
                {exp_req[0], exp_lamp[0], |exp_lamp[0], exp_req[1], exp_lamp[1], |exp_lamp[1]}) begin
                n_fail++;
                $display("FAIL random_cycle c=%0d got a=%b/%b/%b b=%b/%b/%b exp a=%b/%b b=%b/%b",
                         c, req_a, lamp_a, any_a, req_b, lamp_b, any_b,
                         exp_req[0], exp_lamp[0], exp_req[1], exp_lamp[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_latency();
        test_glitch();
        test_service();
        test_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
